// File: rtl/key_expand_pkg.sv
// Shared definitions for the AES-128 key expansion controller: FSM encoding,
// schedule limits and the GF(2^8) helpers used by the round-constant update.
package key_expand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [5:0] LAST_IDX   = 6'd43;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_word_step.sv
// One step of the AES-128 key schedule: w[i] = w[i-4] ^ temp, where temp is
// the substituted word plus round constant on every fourth word, else w[i-1].
module key_word_step
  import key_expand_pkg::*;
(
  input  logic [31:0] w_prev4,
  input  logic [31:0] w_prev1,
  input  logic [31:0] sub_word,
  input  logic [7:0]  rcon,
  input  logic        rcon_step,
  output logic [31:0] w_next
);

  logic [31:0] temp;

  always_comb begin
    temp = w_prev1;
    if (rcon_step) begin
      temp = sub_word ^ {rcon, 24'h0};
    end
    w_next = w_prev4 ^ temp;
  end

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion controller: streams w0..w43 over a valid/ready
// handshake, using an external combinational S-box for SubWord.
module key_expand_ctrl
  import key_expand_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_index,
  output logic         busy,
  output logic         done
);

  state_t      state;
  logic [31:0] win [4];
  logic [7:0]  rcon;
  logic        accept;
  logic        rcon_step;
  logic [1:0]  load_sel;
  logic [31:0] w_next;

  assign accept    = w_valid && w_ready;
  assign load_sel  = w_index[1:0] + 2'd1;
  // The word being computed is w_index+1, so it takes the S-box path when w_index%4==3.
  assign rcon_step = (w_index[1:0] == 2'd3);
  assign sbox_in   = (state == ST_IDLE) ? 32'h0 : rot_word(win[3]);

  key_word_step u_step (
    .w_prev4   (win[0]),
    .w_prev1   (win[3]),
    .sub_word  (sbox_out),
    .rcon      (rcon),
    .rcon_step (rcon_step),
    .w_next    (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      w_valid <= 1'b0;
      w_out   <= '0;
      w_index <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rcon    <= RCON_INIT;
      for (int k = 0; k < 4; k++) begin
        win[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            win[0]  <= key_in[127:96];
            win[1]  <= key_in[95:64];
            win[2]  <= key_in[63:32];
            win[3]  <= key_in[31:0];
            w_out   <= key_in[127:96];
            w_index <= '0;
            w_valid <= 1'b1;
            busy    <= 1'b1;
            rcon    <= RCON_INIT;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (w_index == 6'd3) begin
              // Window already holds w0..w3; w4 is produced as w3 is taken.
              w_out   <= w_next;
              win[0]  <= win[1];
              win[1]  <= win[2];
              win[2]  <= win[3];
              win[3]  <= w_next;
              w_index <= w_index + 6'd1;
              state   <= ST_EXPAND;
            end else begin
              w_out   <= win[load_sel];
              w_index <= w_index + 6'd1;
            end
          end
        end
        ST_EXPAND: begin
          if (accept) begin
            if (w_index == LAST_IDX) begin
              w_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end else begin
              w_out   <= w_next;
              win[0]  <= win[1];
              win[1]  <= win[2];
              win[2]  <= win[3];
              win[3]  <= w_next;
              w_index <= w_index + 6'd1;
              if (w_index[1:0] == 2'd0) begin
                rcon <= xtime(rcon);
              end
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
